// File: rtl/fa_pkg.sv
// fa_pkg: shared FSM state and operation encodings for the serial adder.
// Rev 1.0
`default_nettype none

package fa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fa_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fa_digit_add.sv
// fa_digit_add: combinational DIGIT-bit ripple chain of full-adder cells.
// Rev 1.0
`default_nettype none

module fa_digit_add #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  // Carry into the top cell; on the last step this is the carry into the word MSB.
  assign cout  = c[DIGIT];
  assign c_top = c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/fa_serial_adder.sv
// fa_serial_adder: multi-cycle add/subtract, DIGIT bits per clock, valid/ready in and out.
// Rev 1.0
`default_nettype none

module fa_serial_adder
  import fa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  fa_state_t         state;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  opnd_a;
  logic [WIDTH-1:0]  opnd_b;
  logic              carry;

  logic [DIGIT-1:0]  dig_a;
  logic [DIGIT-1:0]  dig_b;
  logic [DIGIT-1:0]  dig_s;
  logic              dig_cout;
  logic              dig_ctop;

  assign dig_a = opnd_a[int'(step)*DIGIT +: DIGIT];
  assign dig_b = opnd_b[int'(step)*DIGIT +: DIGIT];

  fa_digit_add #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (dig_a),
    .b     (dig_b),
    .cin   (carry),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_top (dig_ctop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            opnd_a   <= a;
            opnd_b   <= (op == OP_SUB) ? ~b : b;
            carry    <= (op == OP_SUB) ? 1'b1 : cin;
            step     <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[int'(step)*DIGIT +: DIGIT] <= dig_s;
          carry <= dig_cout;
          step  <= step + 1'b1;
          if (step == LAST_STEP) begin
            cout      <= dig_cout;
            ovf       <= dig_cout ^ dig_ctop;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fa_serial_adder.sv
// tb_fa_serial_adder: three digit widths driven in lockstep, checked against an arithmetic model.
// Rev 1.0
`default_nettype none

module tb_fa_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_ready;

  // Instance 0: DIGIT=2, instance 1: DIGIT=1, instance 2: DIGIT=8
  logic         ir [3];
  logic         ov [3];
  logic [W-1:0] sm [3];
  logic         co [3];
  logic         of [3];

  int checks   = 0;
  int failures = 0;
  int exp_lat [3] = '{4, 8, 1};

  always #5 clk = ~clk;

  fa_serial_adder #(.WIDTH(W), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sm[0]), .cout(co[0]), .ovf(of[0])
  );

  fa_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sm[1]), .cout(co[1]), .ovf(of[1])
  );

  fa_serial_adder #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sm[2]), .cout(co[2]), .ovf(of[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from the true signed result.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic o, output logic [W-1:0] s, output logic cy,
                       output logic ov_e);
    int r, sr, sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o) begin
      r  = int'(x) - int'(y);
      cy = (x >= y);
      sr = sx - sy;
    end else begin
      r  = int'(x) + int'(y) + int'(c);
      cy = (r > 255);
      sr = sx + sy + int'(c);
    end
    s    = r[W-1:0];
    ov_e = (sr > 127) || (sr < -128);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ir[0] && ir[1] && ir[2]) && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", {31'd0, ir[0] & ir[1] & ir[2]}, 32'd1);
  endtask

  task automatic randomize_inputs();
    in_valid = 1'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    op       = 1'($urandom);
  endtask

  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                     input logic to, input int hold_cycles);
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat [3];
    model(ta, tb_, tc, to, es, ec, eo);
    wait_ready();
    a = ta; b = tb_; cin = tc; op = to; in_valid = 1'b1;
    tick();
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 12; cyc++) begin
      randomize_inputs();
      tick();
      for (int k = 0; k < 3; k++)
        if (ov[k] && lat[k] == 0) lat[k] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lat_d%0d", k), lat[k], exp_lat[k]);
      check($sformatf("sum_d%0d", k), {24'd0, sm[k]}, {24'd0, es});
      check($sformatf("cout_d%0d", k), {31'd0, co[k]}, {31'd0, ec});
      check($sformatf("ovf_d%0d", k), {31'd0, of[k]}, {31'd0, eo});
    end
    for (int h = 0; h < hold_cycles; h++) begin
      randomize_inputs();
      tick();
      check("bp_valid", {31'd0, ov[0]}, 32'd1);
      check("bp_ready", {31'd0, ir[0]}, 32'd0);
      check("bp_sum", {24'd0, sm[0]}, {24'd0, es});
      check("bp_flags", {30'd0, co[0], of[0]}, {30'd0, ec, eo});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_ready_d%0d", k), {31'd0, ir[k]}, 32'd1);
      check($sformatf("post_valid_d%0d", k), {31'd0, ov[k]}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready_d%0d", k), {31'd0, ir[k]}, 32'd1);
      check($sformatf("rst_valid_d%0d", k), {31'd0, ov[k]}, 32'd0);
      check($sformatf("rst_out_d%0d", k), {22'd0, sm[k], co[k], of[k]}, 32'd0);
    end

    txn(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    txn(8'hFF, 8'h01, 1'b1, 1'b0, 0);
    txn(8'h7F, 8'h00, 1'b1, 1'b0, 1);
    txn(8'h10, 8'h20, 1'b1, 1'b1, 0);
    txn(8'h80, 8'h01, 1'b1, 1'b1, 5);

    // Reset while the DIGIT=2 instance is about to execute step 2.
    wait_ready();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; op = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_ready_d%0d", k), {31'd0, ir[k]}, 32'd1);
      check($sformatf("midrst_valid_d%0d", k), {31'd0, ov[k]}, 32'd0);
      check($sformatf("midrst_sum_d%0d", k), {24'd0, sm[k]}, 32'd0);
    end
    txn(8'h01, 8'h01, 1'b0, 1'b0, 0);

    for (int i = 0; i < 25; i++)
      txn(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fa_serial_adder.md
Name: fa_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor that replaces the single-bit combinational full-adder cell in datapaths where area matters more than latency. It processes WIDTH-bit operands DIGIT bits per clock through a DIGIT-bit ripple chain of full-adder cells, with a registered carry between steps. Operands enter and results leave through valid/ready handshakes, so the block drops between any producer/consumer pair in the arithmetic datapath.

Parameters:
WIDTH, 8, operand and result width in bits; must be an integer multiple of DIGIT.
DIGIT, 2, bits processed per cycle; 1 gives bit-serial, WIDTH gives a single-step ripple.
STEPS, WIDTH/DIGIT, derived localparam, number of compute cycles; not overridable.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and op valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; used only when op=0.
op  input  1  0 = add (a+b+cin), 1 = subtract (a-b, computed as a+~b+1; cin ignored).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result.
cout  output  1  carry out of MSB; in subtract mode 1 = no borrow (a >= b unsigned).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, step counter=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 from the first cycle after reset. Reset overrides all other events.
- States: IDLE, RUN, HOLD. in_ready=1 only in IDLE; out_valid=1 only in HOLD.
- IDLE: on an edge with in_valid=1, capture a, b (b inverted when op=1), and the carry seed (cin when op=0, 1 when op=1). Clear the step counter and go to RUN. With in_valid=0, stay in IDLE.
- RUN: each edge adds digit [step*DIGIT +: DIGIT] of the captured operands plus the carry register. It writes the digit into sum, updates the carry register and increments step.
  - On the final step (step=STEPS-1), register cout, compute ovf from the carry into and out of the MSB, and go to HOLD.
  - In-flight inputs (a, b, cin, op, in_valid) are ignored during RUN.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge (8/2 gives 4 cycles; DIGIT=WIDTH gives 1 cycle).
- HOLD: sum, cout and ovf are stable for as long as out_valid=1. On an edge with out_ready=1, go to IDLE, with in_ready=1 the next cycle. There is no overlap: a new operand cannot be accepted in the same cycle a result is consumed.
- Back-pressure: out_ready=0 holds HOLD indefinitely; in_valid is ignored meanwhile.
- sum keeps its last value after leaving HOLD until the next RUN overwrites it digit by digit.
- Width rules: all internal arithmetic is DIGIT+1 bits per step. Results wrap modulo 2^WIDTH; cout and ovf report the wrap.

Decomposition:
- Shared package fa_pkg holds the state enum (IDLE/RUN/HOLD), OP_ADD=0 and OP_SUB=1.
- One sub-module, fa_digit_add: a purely combinational DIGIT-bit ripple adder of full-adder cells. Its outputs are DIGIT-bit sum, carry out, and carry into the top bit (needed for ovf).
- The top level holds the FSM, step counter, operand/result registers and handshakes.

Test Plan:
1. WIDTH=8, DIGIT=2, op=0: a=8'h5A, b=8'h3C, cin=0 -> sum=8'h96, cout=0, ovf=1. out_valid rises 4 cycles after the accept edge.
2. op=0: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0. op=0: a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
3. op=1 (cin driven 1, must be ignored): a=8'h10, b=8'h20 -> sum=8'hF0, cout=0, ovf=0. op=1: a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
4. Back-pressure: hold out_ready=0 for 5 cycles in HOLD while toggling in_valid/a/b -> sum, cout, ovf and out_valid stay unchanged and in_ready stays 0. Raise out_ready -> in_ready=1 the next cycle.
5. Assert rst during RUN step 2 -> next cycle: state IDLE, in_ready=1, out_valid=0, sum=0. A following add of 8'h01+8'h01 gives 8'h02 with no stale carry.
6. Re-parametrise DIGIT=1, then DIGIT=8 -> the case 1 vectors give identical results, with latency 8 and 1 cycles respectively.
